// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: buffers one feature vector, then computes each
// output row on a single shared MAC fed by an external one-cycle-latency weight memory.
module fc_layer_seq #(
  parameter int BITWIDTH = 8,
  parameter int IN_LEN   = 10,
  parameter int OUT_LEN  = 10,
  parameter int SHIFT    = 7,
  parameter int RELU_EN  = 0,
  parameter int ACC_W    = 2*BITWIDTH+$clog2(IN_LEN)+1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [BITWIDTH-1:0]                    in_data,
  output logic                                          w_rd_en,
  output logic [((IN_LEN*OUT_LEN > 1) ? $clog2(IN_LEN*OUT_LEN) : 1)-1:0] w_addr,
  input  logic signed [BITWIDTH-1:0]                    w_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [BITWIDTH-1:0]                    out_data,
  output logic                                          out_last
);

  localparam int BW = BITWIDTH;
  localparam int AW = (IN_LEN*OUT_LEN > 1) ? $clog2(IN_LEN*OUT_LEN) : 1;
  localparam int IW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int KW = $clog2(IN_LEN+1);
  localparam int JW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(BW-1))-1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t                   state_r;
  logic [IW-1:0]            i_r;
  logic [KW-1:0]            k_r;
  logic [JW-1:0]            j_r;
  logic [AW-1:0]            row_base_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [BW-1:0]     feat_r [IN_LEN];
  logic                     in_ready_r;
  logic                     w_rd_en_r;
  logic [AW-1:0]            w_addr_r;
  logic                     out_valid_r;
  logic signed [BW-1:0]     out_data_r;
  logic                     out_last_r;

  logic [IW-1:0]            feat_idx_s;
  logic signed [BW-1:0]     feat_op_s;
  logic [2*BW-1:0]          mul_s;
  logic signed [ACC_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]  acc_next_s;

  // Floor-shift, saturate, then optionally clamp negatives to zero.
  function automatic logic signed [BW-1:0] rescale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic signed [BW-1:0]    r;
    sh = a >>> SHIFT;
    if (sh > SAT_MAX) begin
      r = SAT_MAX[BW-1:0];
    end else if (sh < SAT_MIN) begin
      r = SAT_MIN[BW-1:0];
    end else begin
      r = sh[BW-1:0];
    end
    if ((RELU_EN != 0) && r[BW-1]) begin
      r = '0;
    end
    return r;
  endfunction

  // MAC datapath: cycle k multiplies feat[k-1] by the weight read in cycle k-1.
  always_comb begin
    feat_idx_s = '0;
    if (k_r != '0) begin
      feat_idx_s = IW'(k_r - KW'(1));
    end else begin
      feat_idx_s = '0;
    end
    feat_op_s  = feat_r[feat_idx_s];
    mul_s      = {{BW{feat_op_s[BW-1]}}, feat_op_s} * {{BW{w_data[BW-1]}}, w_data};
    prod_s     = {{(ACC_W-2*BW){mul_s[2*BW-1]}}, mul_s};
    acc_next_s = (k_r == KW'(1)) ? prod_s : (acc_r + prod_s);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LOAD;
      i_r         <= '0;
      k_r         <= '0;
      j_r         <= '0;
      row_base_r  <= '0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      w_rd_en_r   <= 1'b0;
      w_addr_r    <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (in_valid && in_ready_r) begin
            feat_r[i_r] <= in_data;
            if (i_r == IW'(IN_LEN-1)) begin
              i_r        <= '0;
              j_r        <= '0;
              k_r        <= '0;
              row_base_r <= '0;
              in_ready_r <= 1'b0;
              w_rd_en_r  <= 1'b1;
              w_addr_r   <= '0;
              state_r    <= COMPUTE;
            end else begin
              i_r <= i_r + IW'(1);
            end
          end
        end
        COMPUTE: begin
          if (k_r != '0) begin
            acc_r <= acc_next_s;
          end
          if (k_r == KW'(IN_LEN)) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rescale(acc_next_s);
            out_last_r  <= (j_r == JW'(OUT_LEN-1));
            w_rd_en_r   <= 1'b0;
            w_addr_r    <= '0;
            state_r     <= EMIT;
          end else begin
            k_r <= k_r + KW'(1);
            if ((k_r + KW'(1)) < KW'(IN_LEN)) begin
              w_rd_en_r <= 1'b1;
              w_addr_r  <= w_addr_r + AW'(1);
            end else begin
              w_rd_en_r <= 1'b0;
              w_addr_r  <= '0;
            end
          end
        end
        EMIT: begin
          // Everything holds while the consumer stalls.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (out_last_r) begin
              i_r        <= '0;
              in_ready_r <= 1'b1;
              state_r    <= LOAD;
            end else begin
              j_r        <= j_r + JW'(1);
              k_r        <= '0;
              row_base_r <= row_base_r + AW'(IN_LEN);
              w_rd_en_r  <= 1'b1;
              w_addr_r   <= row_base_r + AW'(IN_LEN);
              state_r    <= COMPUTE;
            end
          end
        end
        default: begin
          state_r     <= LOAD;
          in_ready_r  <= 1'b1;
          w_rd_en_r   <= 1'b0;
          w_addr_r    <= '0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign w_rd_en   = w_rd_en_r;
  assign w_addr    = w_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: plain and ReLU instances share stimulus; directed table,
// reset-abort sequence and random vectors are checked against an arithmetic model.
module tb_fc_layer_seq;
  localparam int BW = 8;
  localparam int IN_LEN = 10;
  localparam int OUT_LEN = 10;
  localparam int SHIFT = 7;
  localparam int AW = $clog2(IN_LEN*OUT_LEN);

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [BW-1:0] in_data;
  logic out_ready;
  logic in_ready0, w_rd_en0, out_valid0, out_last0;
  logic [AW-1:0] w_addr0;
  logic signed [BW-1:0] w_data0, out_data0;
  logic in_ready1, w_rd_en1, out_valid1, out_last1;
  logic [AW-1:0] w_addr1;
  logic signed [BW-1:0] w_data1, out_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic signed [BW-1:0] wmem [IN_LEN*OUT_LEN];
  logic signed [BW-1:0] feat [IN_LEN];

  always #5 clk = ~clk;

  fc_layer_seq #(.BITWIDTH(BW), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .SHIFT(SHIFT), .RELU_EN(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .w_rd_en(w_rd_en0), .w_addr(w_addr0), .w_data(w_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0));

  fc_layer_seq #(.BITWIDTH(BW), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .SHIFT(SHIFT), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .w_rd_en(w_rd_en1), .w_addr(w_addr1), .w_data(w_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1));

  // Synchronous weight memories; garbage is presented when no read was issued.
  always @(posedge clk) begin
    w_data0 <= w_rd_en0 ? wmem[w_addr0] : 8'($urandom());
    w_data1 <= w_rd_en1 ? wmem[w_addr1] : 8'($urandom());
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model(input int j, input bit relu);
    longint acc, q, d;
    acc = 0;
    for (int i = 0; i < IN_LEN; i++) acc += longint'(feat[i]) * longint'(wmem[j*IN_LEN+i]);
    d = longint'(1) << SHIFT;
    q = acc / d;
    if (acc < 0 && (acc % d) != 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    if (relu && q < 0) q = 0;
    return int'(q);
  endfunction

  task automatic set_feat(input int mode, input int val);
    for (int i = 0; i < IN_LEN; i++) begin
      case (mode)
        0: feat[i] = 8'(2*i);
        1: feat[i] = 8'(val);
        2: feat[i] = (i == 3) ? 8'(val) : 8'sd0;
        default: feat[i] = 8'($urandom());
      endcase
    end
  endtask

  task automatic set_w(input int mode, input int val);
    for (int j = 0; j < OUT_LEN; j++)
      for (int i = 0; i < IN_LEN; i++) begin
        case (mode)
          0: wmem[j*IN_LEN+i] = (i == j) ? 8'(val) : 8'sd0;
          1: wmem[j*IN_LEN+i] = 8'(val);
          2: wmem[j*IN_LEN+i] = (i == 3) ? 8'(val) : 8'sd0;
          default: wmem[j*IN_LEN+i] = 8'($urandom());
        endcase
      end
  endtask

  task automatic load_vec(input bit rand_valid, output int acc_cyc);
    int idx = 0;
    int guard = 0;
    acc_cyc = -1;
    while (idx < IN_LEN && guard < 200) begin
      @(negedge clk); cyc++; guard++;
      chk("load_out_valid", int'(out_valid0 | out_valid1), 0);
      in_valid = rand_valid ? 1'($urandom_range(1, 0)) : 1'b1;
      in_data = feat[idx];
      if (in_valid && in_ready0) begin
        idx++;
        if (idx == IN_LEN) acc_cyc = cyc;
      end
    end
    if (idx < IN_LEN) chk("load_timeout", idx, IN_LEN);
  endtask

  task automatic collect(input bit rand_ready, input int stall_out, input int stall_len,
                         input int acc_cyc, input int exp0 [OUT_LEN], input int exp1 [OUT_LEN]);
    int oi = 0;
    int reads = 0;
    int guard = 0;
    int stall_left = stall_len;
    bit first = 1'b1;
    bit done = 1'b0;
    while (!done && guard < 3000) begin
      @(negedge clk); cyc++; guard++;
      in_valid = 1'($urandom_range(1, 0));
      in_data = 8'($urandom());
      chk("in_ready_busy", in_ready0, 0);
      if (w_rd_en0) begin
        chk("w_addr", int'(w_addr0), reads);
        reads++;
      end
      if (out_valid0) begin
        if (first) begin
          chk("latency", cyc - acc_cyc, IN_LEN + 2);
          first = 1'b0;
        end
        chk("no_read_in_emit", w_rd_en0, 0);
        chk("out_data", out_data0, exp0[oi]);
        chk("out_last", out_last0, (oi == OUT_LEN-1) ? 1 : 0);
        chk("relu_valid", out_valid1, 1);
        chk("relu_data", out_data1, exp1[oi]);
        if (oi == stall_out && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
          if (out_ready) begin
            oi++;
            if (oi == OUT_LEN) done = 1'b1;
          end
        end
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      end
    end
    if (!done) chk("collect_timeout", oi, OUT_LEN);
    @(negedge clk); cyc++;
    in_valid = 1'b0;
    chk("in_ready_after", in_ready0, 1);
    chk("out_valid_after", out_valid0, 0);
    chk("total_reads", reads, IN_LEN*OUT_LEN);
  endtask

  typedef struct {
    int fmode; int fval; int wmode; int wval; int stall_out; int stall_len;
    int exp0 [OUT_LEN]; int exp1 [OUT_LEN];
  } vec_t;

  vec_t tbl [5];

  initial begin
    int acc_cyc;
    int hs;
    int guard;
    int e0 [OUT_LEN];
    int e1 [OUT_LEN];

    // Directed vectors with expected results taken straight from the arithmetic rules.
    tbl[0] = '{fmode:0, fval:0, wmode:0, wval:64, stall_out:-1, stall_len:0, exp0:'{default:0}, exp1:'{default:0}};
    tbl[1] = '{fmode:1, fval:64, wmode:1, wval:64, stall_out:-1, stall_len:0, exp0:'{default:127}, exp1:'{default:127}};
    tbl[2] = '{fmode:1, fval:-128, wmode:1, wval:127, stall_out:-1, stall_len:0, exp0:'{default:-128}, exp1:'{default:0}};
    tbl[3] = '{fmode:2, fval:-1, wmode:2, wval:1, stall_out:-1, stall_len:0, exp0:'{default:-1}, exp1:'{default:0}};
    tbl[4] = '{fmode:0, fval:0, wmode:0, wval:64, stall_out:4, stall_len:5, exp0:'{default:0}, exp1:'{default:0}};
    for (int j = 0; j < OUT_LEN; j++) begin
      tbl[0].exp0[j] = j; tbl[0].exp1[j] = j;
      tbl[4].exp0[j] = j; tbl[4].exp1[j] = j;
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) begin @(negedge clk); cyc++; end
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_last", out_last0, 0);
    chk("rst_w_rd_en", w_rd_en0, 0);
    chk("rst_w_addr", int'(w_addr0), 0);
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      set_feat(tbl[t].fmode, tbl[t].fval);
      set_w(tbl[t].wmode, tbl[t].wval);
      load_vec(1'b0, acc_cyc);
      collect(1'b0, tbl[t].stall_out, tbl[t].stall_len, acc_cyc, tbl[t].exp0, tbl[t].exp1);
    end

    // Abort mid-computation of output 2, then a fresh vector must come out clean.
    set_feat(0, 0); set_w(0, 64);
    load_vec(1'b0, acc_cyc);
    hs = 0; guard = 0;
    while (hs < 2 && guard < 500) begin
      @(negedge clk); cyc++; guard++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (out_valid0) begin
        chk("pre_reset_data", out_data0, hs);
        hs++;
      end
    end
    if (hs < 2) chk("pre_reset_timeout", hs, 2);
    repeat (3) begin @(negedge clk); cyc++; end
    chk("mid_compute_rd", w_rd_en0, 1);
    rst = 1'b1;
    @(negedge clk); cyc++;
    rst = 1'b0;
    chk("abort_out_valid", out_valid0, 0);
    chk("abort_in_ready", in_ready0, 1);
    chk("abort_w_rd_en", w_rd_en0, 0);
    load_vec(1'b1, acc_cyc);
    collect(1'b0, -1, 0, acc_cyc, tbl[0].exp0, tbl[0].exp1);

    // Random vectors with random valid/ready gaps.
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin
        set_feat(3, 0); set_w(3, 0);
      end else begin
        for (int i = 0; i < IN_LEN; i++) feat[i] = 8'(int'($urandom_range(31, 0)) - 16);
        for (int a = 0; a < IN_LEN*OUT_LEN; a++) wmem[a] = 8'(int'($urandom_range(63, 0)) - 32);
      end
      for (int j = 0; j < OUT_LEN; j++) begin
        e0[j] = model(j, 1'b0);
        e1[j] = model(j, 1'b1);
      end
      load_vec(1'b1, acc_cyc);
      collect(1'b1, -1, 0, acc_cyc, e0, e1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Sequential, parametrised fully-connected layer for the LeNet classifier tail. It accepts an IN_LEN-element feature vector over a valid/ready stream and fetches weights from an external synchronous ROM/RAM one word per cycle. It computes OUT_LEN dot products on a single shared MAC and emits each result, rescaled, saturated and optionally ReLU-clamped, over a valid/ready output stream. It replaces the fully combinational 10x10 layer, cutting multipliers from 100 to 1 and adding backpressure, saturation and ReLU.

## Interface
- BITWIDTH, 8: signed width of features, weights and outputs.
- IN_LEN, 10: input vector length (≥1).
- OUT_LEN, 10: output vector length (≥1).
- SHIFT, 7: arithmetic right shift applied to the accumulator (fixed-point rescale).
- RELU_EN, 0: 1 = clamp negative outputs to 0.
- ACC_W, 2*BITWIDTH+$clog2(IN_LEN)+1: accumulator width; overflow-free by construction.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  feature word valid.
- in_ready  out  1  block can accept a feature word.
- in_data  in  BITWIDTH  signed feature, element 0 first.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  $clog2(IN_LEN*OUT_LEN)  weight address = j*IN_LEN + i (row j = output, column i = input).
- w_data  in  BITWIDTH  signed weight; valid exactly 1 cycle after its w_rd_en.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  BITWIDTH  signed result, element 0 first.
- out_last  out  1  high with element OUT_LEN-1.

## Operation
- States: LOAD, COMPUTE, EMIT.
- LOAD: in_ready=1. Each in_valid&&in_ready cycle writes in_data to feat[i] and increments i. Accepting element IN_LEN-1 moves the FSM to COMPUTE with j=0. in_valid while in_ready=0 is ignored.
- COMPUTE (per output j): IN_LEN+1 cycles.
  - Cycle k = 0..IN_LEN-1: w_rd_en=1, w_addr=j*IN_LEN+k.
  - Cycle k = 1..IN_LEN: acc += feat[k-1]*w_data. The cycle-1 MAC overwrites acc instead of adding, which clears the previous result.
  - After cycle IN_LEN the FSM moves to EMIT.
- EMIT: out_valid=1. out_data = sat(acc >>> SHIFT), with ReLU applied after saturation when RELU_EN=1. out_last = (j==OUT_LEN-1). out_data and out_last stay stable until out_valid&&out_ready.
  - On handshake with j<OUT_LEN-1: j++ and the FSM moves to COMPUTE.
  - On handshake with j==OUT_LEN-1: the FSM moves to LOAD with i=0.
- Arithmetic:
  - Full-precision signed product, sign-extended to ACC_W.
  - Arithmetic shift, floor rounding (no round-to-nearest).
  - Saturation to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Features are buffered. The input stream is not re-read per output row.
- w_rd_en=0 in LOAD and EMIT. w_addr is don't-care when w_rd_en=0 and is driven 0.

## Timing
- Reset values: state=LOAD, i=j=0, acc=0, in_ready=1, out_valid=0, out_data=0, out_last=0, w_rd_en=0, w_addr=0.
- Reset asserted in any state, including mid-COMPUTE or EMIT, aborts the vector on the next edge. The partial result is discarded and never emitted. Outputs take the reset values from the next cycle.
- Latency: last feature accepted at edge t → first w_rd_en in cycle t+1 → out_valid high in cycle t+IN_LEN+2 (t+12 at defaults).
- Per-output cost: IN_LEN+1 compute cycles plus ≥1 EMIT cycle. With out_ready held at 1, one vector takes OUT_LEN*(IN_LEN+2) cycles after load (120 at defaults).
- Backpressure: while out_valid&&!out_ready, no weight reads occur and all state is frozen.
- in_ready is 0 from the cycle after the last feature until the cycle after the final output handshake. A new vector may start on that cycle.
- in_ready and out_valid depend only on registered state (no combinational in→out paths).

## Test plan
- Diagonal: feat[i]=2*i, W[j][i]=64 if i==j else 0, out_ready=1 → outputs 0,1,…,9, out_last only on 9, first out_valid exactly 12 cycles after last feature accept.
- Positive saturation: all feat=64, all W=64 (acc=40960, >>>7 = 320) → all ten outputs 127.
- Negative saturation and ReLU: all feat=-128, all W=127 (acc=-162560, >>>7 = -1270) → outputs -128 with RELU_EN=0; outputs 0 with RELU_EN=1.
- Floor rounding: feat[3]=-1, W[j][3]=1, all others 0 → every output -1 with RELU_EN=0.
- Backpressure: diagonal case, out_ready low for 5 cycles at output 4 → out_data=4 held, no w_rd_en during stall, remaining outputs 5..9 correct, in_ready low throughout.
- Reset mid-COMPUTE of output 2 → next cycle out_valid=0, in_ready=1, w_rd_en=0. A fresh diagonal vector afterwards yields 0..9 with no leftover outputs.
